// File: rtl/scr1_ialu_arb_pkg.sv
// rtl/scr1_ialu_arb_pkg.sv - shared types and helpers for the IALU arbiter
package scr1_ialu_arb_pkg;

    localparam int SCR1_XLEN = 32;

    // Command encoding seen by the shared IALU
    typedef enum logic [4:0] {
        SCR1_IALU_CMD_NONE    = 5'd0,
        SCR1_IALU_CMD_AND     = 5'd1,
        SCR1_IALU_CMD_OR      = 5'd2,
        SCR1_IALU_CMD_XOR     = 5'd3,
        SCR1_IALU_CMD_ADD     = 5'd4,
        SCR1_IALU_CMD_SUB     = 5'd5,
        SCR1_IALU_CMD_SUB_LT  = 5'd6,
        SCR1_IALU_CMD_SUB_LTU = 5'd7,
        SCR1_IALU_CMD_SUB_EQ  = 5'd8,
        SCR1_IALU_CMD_SUB_NE  = 5'd9,
        SCR1_IALU_CMD_SUB_GE  = 5'd10,
        SCR1_IALU_CMD_SUB_GEU = 5'd11,
        SCR1_IALU_CMD_SLL     = 5'd12,
        SCR1_IALU_CMD_SRL     = 5'd13,
        SCR1_IALU_CMD_SRA     = 5'd14,
        SCR1_IALU_CMD_MUL     = 5'd15,
        SCR1_IALU_CMD_MULHU   = 5'd16,
        SCR1_IALU_CMD_MULHSU  = 5'd17,
        SCR1_IALU_CMD_MULH    = 5'd18,
        SCR1_IALU_CMD_DIV     = 5'd19,
        SCR1_IALU_CMD_DIVU    = 5'd20,
        SCR1_IALU_CMD_REM     = 5'd21,
        SCR1_IALU_CMD_REMU    = 5'd22
    } type_scr1_ialu_cmd_sel_e;

    typedef enum logic {
        IDLE,
        RVM_BUSY
    } type_scr1_ialu_arb_fsm_e;

    // Multi-cycle commands go through the IALU's RVM handshake
    function automatic logic is_rvm_cmd(input type_scr1_ialu_cmd_sel_e cmd);
        return (cmd >= SCR1_IALU_CMD_MUL) && (cmd <= SCR1_IALU_CMD_REMU);
    endfunction

endpackage

// File: rtl/scr1_ialu_rr_arb.sv
// rtl/scr1_ialu_rr_arb.sv - round-robin picker with registered priority pointer
module scr1_ialu_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       adv,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [IW:0]   scan;
    logic [IW:0]   inc;
    logic          found;

    // Pick the first asserted request at or after the pointer, wrapping
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NUM_REQ)) begin
                scan = scan - (IW+1)'(NUM_REQ);
            end
            if (!found && req[scan[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan[IW-1:0];
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Next pointer is one past the granted index, modulo NUM_REQ
    always_comb begin
        inc      = {1'b0, grant_idx} + (IW+1)'(1);
        ptr_next = (inc == (IW+1)'(NUM_REQ)) ? '0 : inc[IW-1:0];
    end

    // Pointer advances only when the grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/scr1_ialu_arb.sv
// rtl/scr1_ialu_arb.sv - shares one IALU between several requesters
module scr1_ialu_arb
    import scr1_ialu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = SCR1_XLEN
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_vd_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]              req_op1_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]              req_op2_i,
    input  type_scr1_ialu_cmd_sel_e [NUM_REQ-1:0]     req_cmd_i,
    output logic [NUM_REQ-1:0]                        req_rdy_o,
    output logic                                      resp_vd_o,
    output logic [$clog2(NUM_REQ)-1:0]                resp_id_o,
    output logic [XLEN-1:0]                           resp_res_o,
    output logic                                      resp_cmp_o,
    input  logic                                      resp_rdy_i,
    output logic [XLEN-1:0]                           arb2ialu_op1_o,
    output logic [XLEN-1:0]                           arb2ialu_op2_o,
    output type_scr1_ialu_cmd_sel_e                   arb2ialu_cmd_o,
    output logic                                      arb2ialu_rvm_vd_o,
    input  logic [XLEN-1:0]                           ialu2arb_res_i,
    input  logic                                      ialu2arb_cmp_i,
    input  logic                                      ialu2arb_rvm_rdy_i
);

    localparam int IW = $clog2(NUM_REQ);

    type_scr1_ialu_arb_fsm_e state;
    type_scr1_ialu_arb_fsm_e state_next;

    logic [NUM_REQ-1:0]      rr_grant;
    logic [IW-1:0]           rr_idx;
    logic                    slot_free;
    logic                    accept;
    logic                    rvm_accept;
    logic                    rvm_done;

    logic [XLEN-1:0]         hold_op1;
    logic [XLEN-1:0]         hold_op2;
    type_scr1_ialu_cmd_sel_e hold_cmd;
    logic [IW-1:0]           hold_id;

    // A grant is only possible when its result has somewhere to land
    assign slot_free  = ~resp_vd_o | resp_rdy_i;
    assign accept     = (state == IDLE) & slot_free & (|req_vd_i);
    assign rvm_accept = accept & is_rvm_cmd(req_cmd_i[rr_idx]);
    assign rvm_done   = (state == RVM_BUSY) & ialu2arb_rvm_rdy_i;

    scr1_ialu_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_vd_i),
        .adv       (accept),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant strobes and IALU operand steering
    always_comb begin
        state_next        = state;
        req_rdy_o         = '0;
        arb2ialu_op1_o    = '0;
        arb2ialu_op2_o    = '0;
        arb2ialu_cmd_o    = SCR1_IALU_CMD_NONE;
        arb2ialu_rvm_vd_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_rdy_o      = rr_grant;
                    arb2ialu_op1_o = req_op1_i[rr_idx];
                    arb2ialu_op2_o = req_op2_i[rr_idx];
                    arb2ialu_cmd_o = req_cmd_i[rr_idx];
                    if (rvm_accept) begin
                        state_next = RVM_BUSY;
                    end
                end
            end
            RVM_BUSY: begin
                arb2ialu_op1_o    = hold_op1;
                arb2ialu_op2_o    = hold_op2;
                arb2ialu_cmd_o    = hold_cmd;
                arb2ialu_rvm_vd_o = 1'b1;
                if (ialu2arb_rvm_rdy_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands of a multi-cycle op are held so the requester is free to move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_op1 <= '0;
            hold_op2 <= '0;
            hold_cmd <= SCR1_IALU_CMD_NONE;
            hold_id  <= '0;
        end else if (rvm_accept) begin
            hold_op1 <= req_op1_i[rr_idx];
            hold_op2 <= req_op2_i[rr_idx];
            hold_cmd <= req_cmd_i[rr_idx];
            hold_id  <= rr_idx;
        end
    end

    // Single-entry response register; reload wins over consume for full throughput
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vd_o  <= 1'b0;
            resp_id_o  <= '0;
            resp_res_o <= '0;
            resp_cmp_o <= 1'b0;
        end else if (accept && !rvm_accept) begin
            resp_vd_o  <= 1'b1;
            resp_id_o  <= rr_idx;
            resp_res_o <= ialu2arb_res_i;
            resp_cmp_o <= ialu2arb_cmp_i;
        end else if (rvm_done) begin
            resp_vd_o  <= 1'b1;
            resp_id_o  <= hold_id;
            resp_res_o <= ialu2arb_res_i;
            resp_cmp_o <= ialu2arb_cmp_i;
        end else if (resp_vd_o && resp_rdy_i) begin
            resp_vd_o  <= 1'b0;
            resp_id_o  <= '0;
            resp_res_o <= '0;
            resp_cmp_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scr1_ialu_arb.sv
// tb/tb_scr1_ialu_arb.sv - scoreboard bench for the IALU arbiter
module tb_scr1_ialu_arb;
    import scr1_ialu_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int XLEN    = 32;
    localparam int RVM_LAT = 4;

    typedef struct packed {
        logic [0:0]      id;
        logic [XLEN-1:0] res;
        logic            cmp;
    } exp_t;

    logic                                  clk;
    logic                                  rst_n;
    logic [NUM_REQ-1:0]                    req_vd;
    logic [NUM_REQ-1:0][XLEN-1:0]          req_op1;
    logic [NUM_REQ-1:0][XLEN-1:0]          req_op2;
    type_scr1_ialu_cmd_sel_e [NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]                    req_rdy;
    logic                                  resp_vd;
    logic [0:0]                            resp_id;
    logic [XLEN-1:0]                       resp_res;
    logic                                  resp_cmp;
    logic                                  resp_rdy;
    logic [XLEN-1:0]                       a2i_op1;
    logic [XLEN-1:0]                       a2i_op2;
    type_scr1_ialu_cmd_sel_e               a2i_cmd;
    logic                                  a2i_rvm_vd;
    logic [XLEN-1:0]                       i2a_res;
    logic                                  i2a_cmp;
    logic                                  i2a_rvm_rdy;

    int   checks;
    int   failures;
    exp_t sb[$];
    int   rvm_cnt;

    scr1_ialu_arb #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_vd_i           (req_vd),
        .req_op1_i          (req_op1),
        .req_op2_i          (req_op2),
        .req_cmd_i          (req_cmd),
        .req_rdy_o          (req_rdy),
        .resp_vd_o          (resp_vd),
        .resp_id_o          (resp_id),
        .resp_res_o         (resp_res),
        .resp_cmp_o         (resp_cmp),
        .resp_rdy_i         (resp_rdy),
        .arb2ialu_op1_o     (a2i_op1),
        .arb2ialu_op2_o     (a2i_op2),
        .arb2ialu_cmd_o     (a2i_cmd),
        .arb2ialu_rvm_vd_o  (a2i_rvm_vd),
        .ialu2arb_res_i     (i2a_res),
        .ialu2arb_cmp_i     (i2a_cmp),
        .ialu2arb_rvm_rdy_i (i2a_rvm_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural IALU: combinational main results, fixed-latency multiply
    always_comb begin
        i2a_res = '0;
        i2a_cmp = 1'b0;
        case (a2i_cmd)
            SCR1_IALU_CMD_ADD:    i2a_res = a2i_op1 + a2i_op2;
            SCR1_IALU_CMD_SUB:    i2a_res = a2i_op1 - a2i_op2;
            SCR1_IALU_CMD_SUB_LT: begin
                i2a_res = a2i_op1 - a2i_op2;
                i2a_cmp = $signed(a2i_op1) < $signed(a2i_op2);
            end
            SCR1_IALU_CMD_MUL:    i2a_res = a2i_op1 * a2i_op2;
            default:              i2a_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rvm_cnt <= 0;
        else if (!a2i_rvm_vd || i2a_rvm_rdy) rvm_cnt <= 0;
        else                 rvm_cnt <= rvm_cnt + 1;
    end
    assign i2a_rvm_rdy = a2i_rvm_vd && (rvm_cnt == RVM_LAT - 1);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int id, input logic [XLEN-1:0] res, input logic cmp);
        exp_t e;
        e.id  = 1'(id);
        e.res = res;
        e.cmp = cmp;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // Present one request, wait (bounded) for its accept, then withdraw it
    task automatic issue(input int id, input type_scr1_ialu_cmd_sel_e c,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input logic exp_cmp);
        int n;
        req_cmd[id] = c;
        req_op1[id] = a;
        req_op2[id] = b;
        req_vd[id]  = 1'b1;
        push(id, exp_res, exp_cmp);
        n = 0;
        @(negedge clk);
        while (!req_rdy[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_accept", req_rdy[id], 1'b1);
        tick();
        req_vd[id] = 1'b0;
    endtask

    // Response monitor pops the scoreboard on every consumed response
    always @(negedge clk) begin
        if (rst_n && resp_vd && resp_rdy) begin
            check("sb_avail", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_res", resp_res, e.res);
                check("resp_cmp", resp_cmp, e.cmp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_vd   = '0;
        req_op1  = '0;
        req_op2  = '0;
        req_cmd  = {SCR1_IALU_CMD_NONE, SCR1_IALU_CMD_NONE};
        resp_rdy = 1'b1;

        // Reset state
        idle(2);
        @(negedge clk);
        check("rst_resp_vd", resp_vd, 1'b0);
        check("rst_resp_id", resp_id, 1'b0);
        check("rst_resp_res", resp_res, 0);
        check("rst_req_rdy", req_rdy, 2'b00);
        check("rst_rvm_vd", a2i_rvm_vd, 1'b0);
        check("rst_cmd", a2i_cmd, SCR1_IALU_CMD_NONE);
        check("rst_op1", a2i_op1, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single ADD with same-cycle accept and latency-1 response
        req_cmd[0] = SCR1_IALU_CMD_ADD;
        req_op1[0] = 32'd5;
        req_op2[0] = 32'd3;
        req_vd[0]  = 1'b1;
        push(0, 32'd8, 1'b0);
        @(negedge clk);
        check("add_rdy", req_rdy, 2'b01);
        tick();
        req_vd[0] = 1'b0;
        @(negedge clk);
        check("add_resp_vd", resp_vd, 1'b1);
        tick();

        // Contention from a fresh pointer: 0 first, then strict alternation
        do_reset();
        req_cmd[0] = SCR1_IALU_CMD_ADD;
        req_op1[0] = 32'd1;
        req_op2[0] = 32'd1;
        req_cmd[1] = SCR1_IALU_CMD_SUB;
        req_op1[1] = 32'd10;
        req_op2[1] = 32'd4;
        req_vd     = 2'b11;
        for (int k = 0; k < 6; k++) begin
            push(k % 2, (k % 2 == 0) ? 32'd2 : 32'd6, 1'b0);
            @(negedge clk);
            check("rr_grant", req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_vd = 2'b00;
        idle(2);

        // Backpressure holds the response and blocks new grants
        resp_rdy = 1'b0;
        issue(0, SCR1_IALU_CMD_ADD, 32'd20, 32'd22, 32'd42, 1'b0);
        req_cmd[0] = SCR1_IALU_CMD_ADD;
        req_op1[0] = 32'd3;
        req_op2[0] = 32'd4;
        req_vd[0]  = 1'b1;
        push(0, 32'd7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rdy", req_rdy, 2'b00);
            check("bp_vd", resp_vd, 1'b1);
            check("bp_res", resp_res, 32'd42);
            tick();
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        check("bp_accept", req_rdy, 2'b01);
        tick();
        req_vd[0] = 1'b0;
        @(negedge clk);
        check("bp_new_vd", resp_vd, 1'b1);
        tick();
        idle(1);

        // Multi-cycle MUL from req1 stalls req0 until completion
        req_cmd[1] = SCR1_IALU_CMD_MUL;
        req_op1[1] = 32'h0001_0000;
        req_op2[1] = 32'h10;
        req_vd[1]  = 1'b1;
        push(1, 32'h0010_0000, 1'b0);
        @(negedge clk);
        check("mul_grant", req_rdy, 2'b10);
        check("mul_accept_rvm_vd", a2i_rvm_vd, 1'b0);
        tick();
        req_vd[1]  = 1'b0;
        req_cmd[0] = SCR1_IALU_CMD_ADD;
        req_op1[0] = 32'd9;
        req_op2[0] = 32'd1;
        req_vd[0]  = 1'b1;
        push(0, 32'd10, 1'b0);
        for (int k = 0; k < RVM_LAT; k++) begin
            @(negedge clk);
            check("mul_rvm_vd", a2i_rvm_vd, 1'b1);
            check("mul_op1", a2i_op1, 32'h0001_0000);
            check("mul_op2", a2i_op2, 32'h10);
            check("mul_cmd", a2i_cmd, SCR1_IALU_CMD_MUL);
            check("mul_stall", req_rdy, 2'b00);
            tick();
        end
        @(negedge clk);
        check("mul_done_rvm_vd", a2i_rvm_vd, 1'b0);
        check("mul_resp_vd", resp_vd, 1'b1);
        check("post_mul_grant", req_rdy, 2'b01);
        tick();
        req_vd[0] = 1'b0;
        idle(2);

        // Modulo arithmetic at the word boundary and a signed compare
        issue(0, SCR1_IALU_CMD_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        issue(0, SCR1_IALU_CMD_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        issue(1, SCR1_IALU_CMD_SUB_LT, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFA, 1'b1);
        idle(2);

        // Reset while an RVM op is in flight discards it
        req_cmd[0] = SCR1_IALU_CMD_MUL;
        req_op1[0] = 32'd3;
        req_op2[0] = 32'd3;
        req_vd[0]  = 1'b1;
        @(negedge clk);
        check("rvm2_grant", req_rdy, 2'b01);
        tick();
        req_vd[0] = 1'b0;
        @(negedge clk);
        check("rvm2_busy", a2i_rvm_vd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rvm_vd", a2i_rvm_vd, 1'b0);
        check("midrst_resp_vd", resp_vd, 1'b0);
        check("midrst_cmd", a2i_cmd, SCR1_IALU_CMD_NONE);
        idle(2);
        rst_n = 1'b1;
        tick();
        issue(0, SCR1_IALU_CMD_ADD, 32'd2, 32'd2, 32'd4, 1'b0);
        idle(3);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scr1_ialu_arb.md
Name: scr1_ialu_arb

Overview:
- Shares one scr1_pipe_ialu instance between NUM_REQ requesters using a valid/ready request side and a single-entry registered response.
- Main-ALU commands (ADD, SUB, logic, shifts, compares) complete in one cycle.
- RVM commands (MUL/DIV/REM family) are sequenced through the IALU's multi-cycle interface: the arbiter holds the grant until ialu2exu_rvm_res_rdy_o.
- Sits between EXU-side requesters and the IALU; the address adder is not arbitrated.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- XLEN, `SCR1_XLEN, operand/result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_vd_i  in  NUM_REQ  per-requester request valid
- req_op1_i  in  NUM_REQ x XLEN  operand 1 per requester
- req_op2_i  in  NUM_REQ x XLEN  operand 2 per requester
- req_cmd_i  in  NUM_REQ x type_scr1_ialu_cmd_sel_e  command per requester
- req_rdy_o  out  NUM_REQ  accept strobe, one-hot or zero
- resp_vd_o  out  1  response valid
- resp_id_o  out  $clog2(NUM_REQ)  requester index of the response
- resp_res_o  out  XLEN  result
- resp_cmp_o  out  1  comparison result
- resp_rdy_i  in  1  response consumed
- arb2ialu_op1_o  out  XLEN  to exu2ialu_main_op1_i
- arb2ialu_op2_o  out  XLEN  to exu2ialu_main_op2_i
- arb2ialu_cmd_o  out  type_scr1_ialu_cmd_sel_e  to exu2ialu_cmd_i
- arb2ialu_rvm_vd_o  out  1  to exu2ialu_rvm_cmd_vd_i
- ialu2arb_res_i  in  XLEN  from ialu2exu_main_res_o
- ialu2arb_cmp_i  in  1  from ialu2exu_cmp_res_o
- ialu2arb_rvm_rdy_i  in  1  from ialu2exu_rvm_res_rdy_o

Behaviour:
- Clock/reset: one clock clk; rst_n asynchronous, active-low.
- Reset values: state=IDLE, resp_vd_o=0, resp_id_o=0, resp_res_o=0, resp_cmp_o=0, req_rdy_o=0, arb2ialu_rvm_vd_o=0, arb2ialu_cmd_o=SCR1_IALU_CMD_NONE, operand outputs 0, rr pointer=0.
- States: IDLE, RVM_BUSY.
- Response slot is free when resp_vd_o=0, or when resp_vd_o & resp_rdy_i in the same cycle.
- IDLE with a free slot:
  - Round-robin selects the lowest index at or after the pointer, wrapping, among asserted req_vd_i.
  - req_rdy_o[g] is asserted combinationally and the granted operands/cmd drive the IALU outputs combinationally.
  - Main command: capture ialu2arb_res_i, ialu2arb_cmp_i and g at the clock edge; resp_vd_o=1 next cycle (latency 1). Stay in IDLE.
  - RVM command: latch operands, cmd and id into hold registers; go to RVM_BUSY.
  - Pointer moves to g+1 mod NUM_REQ on every accept.
- IDLE without a free slot: req_rdy_o=0, cmd output=NONE, no grant.
- RVM_BUSY:
  - Drive the held operands/cmd with arb2ialu_rvm_vd_o=1.
  - req_rdy_o=0 for all requesters.
  - On ialu2arb_rvm_rdy_i: capture the result, set resp_vd_o=1, go to IDLE. A new grant is not allowed in that same cycle.
  - Entry into RVM_BUSY requires a free slot, so the response register is empty on completion.
- Response register: holds value and id stable while resp_vd_o & ~resp_rdy_i. It clears on consume unless reloaded in the same cycle (back-to-back throughput of 1 per cycle for main ops).
- Requester rule: operands/cmd stay stable while req_vd_i=1 until req_rdy_o. The arbiter does not check this.
- Arithmetic: no width change; results are modulo 2^XLEN, taken directly from the IALU.
- Simultaneous requests: exactly one grant per cycle; a starved requester is served within NUM_REQ grants.
- Reset mid-operation (any state): all outputs return to reset values immediately. An in-flight RVM op and an unconsumed response are discarded. The IALU receives the same rst_n.

Decomposition:
- Package scr1_ialu_arb_pkg holds:
  - state enum type_scr1_ialu_arb_fsm_e {IDLE, RVM_BUSY};
  - function is_rvm_cmd(type_scr1_ialu_cmd_sel_e) returning 1 for MUL..REMU.
- Sub-module scr1_ialu_rr_arb: parameterised round-robin picker with registered pointer. Inputs are the request vector and an advance strobe; outputs are the one-hot grant and the grant index.

Test Plan:
- Single ADD from req0, op1=5, op2=3, resp_rdy_i=1 -> req_rdy_o=01 same cycle; next cycle resp_vd_o=1, id=0, res=8.
- Both valid after reset: req0 ADD 1+1, req1 SUB 10-4, held -> req0 accepted first (res 2), req1 next cycle (res 6). Repeated conflicts alternate 0,1,0,1.
- Backpressure: resp_rdy_i=0 with a pending response, req0 valid -> req_rdy_o=0, resp_res_o stable for 5 cycles. Raising resp_rdy_i -> accept in that same cycle, new response the next cycle.
- MUL 0x10000*0x10 from req1 with req0 ADD pending, IALU rvm_rdy after 4 cycles -> arb2ialu_rvm_vd_o high 4 cycles with stable operands, req0 stalled. Response id=1, res=0x100000; req0 granted the cycle after.
- Wrap-around: ADD 0xFFFFFFFF+1 -> 0; SUB 0-1 -> 0xFFFFFFFF.
- Assert rst_n=0 during RVM_BUSY -> resp_vd_o=0 and rvm_vd_o=0 immediately. After release, a req0 ADD 2+2 returns 4 with id 0.
